// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op bit indices,
// FSM states, compare codes and flag bit positions.
package alu_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_LD  = 1;
    localparam int OP_ST  = 2;
    localparam int OP_SUB = 3;
    localparam int OP_MUL = 4;
    localparam int OP_CMP = 5;
    localparam int OP_MOV = 6;
    localparam int OP_OR  = 7;
    localparam int OP_AND = 8;
    localparam int OP_NOT = 9;
    localparam int OP_LSL = 10;
    localparam int OP_LSR = 11;
    localparam int OP_W   = 12;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam logic [1:0] CMP_LT = 2'd0;
    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
// The final iteration is held while the result cannot be taken.
module alu_mul_iter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         abort,
    input  logic         start,
    input  logic         hold,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] product,
    output logic         busy
);
    import alu_pkg::*;

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  partial;

    always_comb begin
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        partial = b_q[0] ? a_q : '0;
        product = acc_q + partial;
        done    = busy_q && (cnt_q == LAST);
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            acc_d  = '0;
            a_d    = a;
            b_d    = b;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q && !(done && hold)) begin
            acc_d = product;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu_pipe.sv
// Execute-stage ALU with registered valid/ready output and iterative MUL.
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} alu_flags output.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IMM_W   = 5,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alusignals,
    input  logic [INSTR_W-1:0] instrin,
    input  logic [DATA_W-1:0]  op1,
    input  logic [DATA_W-1:0]  op2,
    input  logic [IMM_W-1:0]   immx,
    input  logic               isimmediate,
    input  logic               iswb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  aluresult,
    output logic [INSTR_W-1:0] instrout,
    output logic [DATA_W-1:0]  op2_out,
    output logic               isld1,
    output logic               isst1,
    output logic               iswb_out,
    output logic               busy
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]         alu_flags
`endif
);

    localparam int MSB = DATA_W - 1;
    localparam int SW  = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] W_LIM = DATA_W'(DATA_W);

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   op2o_q, op2o_d;
    logic                ld_q, ld_d;
    logic                st_q, st_d;
    logic                wb_q, wb_d;
    logic [INSTR_W-1:0]  m_instr_q, m_instr_d;
    logic [DATA_W-1:0]   m_op2_q, m_op2_d;
    logic                m_wb_q, m_wb_d;

    logic [OP_W-1:0]     op_sel;
    logic [DATA_W-1:0]   a, b, res;
    logic                can_load, accept, is_mul;
    logic                mul_start, mul_done, mul_busy;
    logic [DATA_W-1:0]   mul_product;

    assign a        = op1;
    assign b        = isimmediate ? DATA_W'(immx) : op2;
    // Lowest set bit wins when several ops are flagged.
    assign op_sel   = alusignals & (~alusignals + 1'b1);
    assign is_mul   = op_sel[OP_MUL];
    assign can_load = !valid_q || out_ready;
    assign in_ready = !flush && (state_q == IDLE) && can_load;
    assign accept   = in_valid && in_ready;
    assign mul_start = accept && is_mul;

    always_comb begin
        res = '0;
        unique case (1'b1)
            op_sel[OP_ADD], op_sel[OP_LD], op_sel[OP_ST]: res = a + b;
            op_sel[OP_SUB]: res = a - b;
            op_sel[OP_CMP]: begin
                if (a == b)     res = DATA_W'(CMP_EQ);
                else if (a > b) res = DATA_W'(CMP_GT);
                else            res = DATA_W'(CMP_LT);
            end
            op_sel[OP_MOV]: res = b;
            op_sel[OP_OR]:  res = a | b;
            op_sel[OP_AND]: res = a & b;
            op_sel[OP_NOT]: res = ~a;
            op_sel[OP_LSL]: res = (b >= W_LIM) ? '0 : a << b[SW-1:0];
            op_sel[OP_LSR]: res = (b >= W_LIM) ? '0 : a >> b[SW-1:0];
            default:        res = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic [3:0] fl;

    always_comb begin
        fl = '0;
        fl[FLAG_N] = res[MSB];
        fl[FLAG_Z] = (res == '0);
        if (op_sel[OP_ADD] || op_sel[OP_LD] || op_sel[OP_ST]) begin
            fl[FLAG_C] = (res < a);
            fl[FLAG_V] = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
        end else if (op_sel[OP_SUB]) begin
            fl[FLAG_C] = (a < b);
            fl[FLAG_V] = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
        end
    end
`endif

    alu_mul_iter #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .abort   (flush),
        .start   (mul_start),
        .hold    (!can_load),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product),
        .busy    (mul_busy)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        result_d  = result_q;
        instr_d   = instr_q;
        op2o_d    = op2o_q;
        ld_d      = ld_q;
        st_d      = st_q;
        wb_d      = wb_q;
        m_instr_d = m_instr_q;
        m_op2_d   = m_op2_q;
        m_wb_d    = m_wb_q;
`ifdef ALU_FLAGS_EN
        flags_d   = flags_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            if (valid_q && out_ready) valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept && is_mul) begin
                        state_d   = MUL;
                        m_instr_d = instrin;
                        m_op2_d   = op2;
                        m_wb_d    = iswb;
                    end else if (accept) begin
                        valid_d  = 1'b1;
                        result_d = res;
                        instr_d  = instrin;
                        op2o_d   = op2;
                        ld_d     = op_sel[OP_LD];
                        st_d     = op_sel[OP_ST];
                        wb_d     = iswb;
`ifdef ALU_FLAGS_EN
                        flags_d  = fl;
`endif
                    end
                end
                MUL: begin
                    if (mul_done && can_load) begin
                        state_d  = IDLE;
                        valid_d  = 1'b1;
                        result_d = mul_product;
                        instr_d  = m_instr_q;
                        op2o_d   = m_op2_q;
                        ld_d     = 1'b0;
                        st_d     = 1'b0;
                        wb_d     = m_wb_q;
`ifdef ALU_FLAGS_EN
                        flags_d  = {mul_product[MSB], mul_product == '0, 2'b00};
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            result_q  <= '0;
            instr_q   <= '0;
            op2o_q    <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            wb_q      <= 1'b0;
            m_instr_q <= '0;
            m_op2_q   <= '0;
            m_wb_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
            flags_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            instr_q   <= instr_d;
            op2o_q    <= op2o_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            wb_q      <= wb_d;
            m_instr_q <= m_instr_d;
            m_op2_q   <= m_op2_d;
            m_wb_q    <= m_wb_d;
`ifdef ALU_FLAGS_EN
            flags_q   <= flags_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign aluresult = result_q;
    assign instrout  = instr_q;
    assign op2_out   = op2o_q;
    assign isld1     = ld_q;
    assign isst1     = st_q;
    assign iswb_out  = wb_q;
    // FSM state is authoritative; the multiplier's own flag mirrors it.
    assign busy      = (state_q == MUL) && mul_busy;
`ifdef ALU_FLAGS_EN
    assign alu_flags = flags_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe.
// Each task drives one scenario and checks its own expectations.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam logic [11:0] A_ADD = 12'h001;
    localparam logic [11:0] A_LD  = 12'h002;
    localparam logic [11:0] A_SUB = 12'h008;
    localparam logic [11:0] A_MUL = 12'h010;
    localparam logic [11:0] A_CMP = 12'h020;
    localparam logic [11:0] A_MOV = 12'h040;
    localparam logic [11:0] A_OR  = 12'h080;
    localparam logic [11:0] A_AND = 12'h100;
    localparam logic [11:0] A_NOT = 12'h200;
    localparam logic [11:0] A_LSL = 12'h400;
    localparam logic [11:0] A_LSR = 12'h800;

    localparam int NV = 11;
    localparam logic [11:0] T_OP [NV] = '{A_LSL, A_LSL, A_LSR, A_CMP,
        A_CMP, A_CMP, A_OR, A_AND, A_NOT, A_LD | A_SUB, 12'h000};
    localparam logic [15:0] T_A [NV] = '{16'h0001, 16'h0001, 16'h8000,
        16'd5, 16'd7, 16'd2, 16'hF0F0, 16'hF0F0, 16'h00FF, 16'h0010,
        16'h1234};
    localparam logic [15:0] T_B [NV] = '{16'd16, 16'hFFFF, 16'd15,
        16'd5, 16'd3, 16'd9, 16'h0F0F, 16'h0FF0, 16'h0000, 16'h0020,
        16'h5678};
    localparam logic T_IMM [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] T_EXP [NV] = '{16'h0000, 16'h0010, 16'h0001,
        16'd1, 16'd2, 16'd0, 16'hFFFF, 16'h00F0, 16'hFF00, 16'h0030,
        16'h0000};
    localparam logic T_LD [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] alusignals;
    logic [15:0] instrin;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  immx;
    logic        isimmediate;
    logic        iswb;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] aluresult;
    logic [15:0] instrout;
    logic [15:0] op2_out;
    logic        isld1;
    logic        isst1;
    logic        iswb_out;
    logic        busy;
`ifdef ALU_FLAGS_EN
    logic [3:0]  alu_flags;
`endif

    int total  = 0;
    int passed = 0;

    alu_pipe #(.DATA_W(16), .IMM_W(5), .INSTR_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alusignals  (alusignals),
        .instrin     (instrin),
        .op1         (op1),
        .op2         (op2),
        .immx        (immx),
        .isimmediate (isimmediate),
        .iswb        (iswb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluresult   (aluresult),
        .instrout    (instrout),
        .op2_out     (op2_out),
        .isld1       (isld1),
        .isst1       (isst1),
        .iswb_out    (iswb_out),
        .busy        (busy)
`ifdef ALU_FLAGS_EN
        ,
        .alu_flags   (alu_flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [4:0] imm,
                         input logic isimm, input logic wb,
                         input logic [15:0] ins);
        in_valid    = 1'b1;
        alusignals  = op;
        op1         = a;
        op2         = b;
        immx        = imm;
        isimmediate = isimm;
        iswb        = wb;
        instrin     = ins;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alusignals = '0; op1 = '0; op2 = '0; immx = '0;
        isimmediate = 1'b0; iswb = 1'b0; instrin = '0;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid);
        else passed++;
        total++;
        if ({aluresult, instrout, op2_out} !== 48'h0)
            $display("FAIL rst_data got %h want 0", {aluresult, instrout, op2_out});
        else passed++;
        total++;
        if ({isld1, isst1, iswb_out, busy} !== 4'b0)
            $display("FAIL rst_flags got %b want 0000", {isld1, isst1, iswb_out, busy});
        else passed++;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        drive(A_ADD, 16'h0003, 16'h0004, 5'd0, 1'b0, 1'b1, 16'h1111);
        total++;
        if (in_ready !== 1'b1) $display("FAIL add_in_ready got %b want 1", in_ready);
        else passed++;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || aluresult !== 16'h0007)
            $display("FAIL add_result got v=%b %h want v=1 0007", out_valid, aluresult);
        else passed++;
        total++;
        if (iswb_out !== 1'b1 || instrout !== 16'h1111)
            $display("FAIL add_side got wb=%b %h want wb=1 1111", iswb_out, instrout);
        else passed++;
        step();
        total++;
        if (out_valid !== 1'b0) $display("FAIL add_drain got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_sub_imm();
        drive(A_SUB, 16'h0001, 16'h1234, 5'h1F, 1'b1, 1'b0, 16'h2222);
        step();
        in_valid = 1'b0;
        total++;
        if (aluresult !== 16'hFFE2)
            $display("FAIL sub_imm got %h want FFE2", aluresult);
        else passed++;
        total++;
        if (op2_out !== 16'h1234 || iswb_out !== 1'b0)
            $display("FAIL sub_op2 got %h wb=%b want 1234 wb=0", op2_out, iswb_out);
        else passed++;
`ifdef ALU_FLAGS_EN
        total++;
        if (alu_flags !== 4'b1010)
            $display("FAIL sub_flags got %b want 1010", alu_flags);
        else passed++;
`endif
        step();
    endtask

    task automatic test_mul();
        int busy_cnt = 0;
        int cyc = 0;
        drive(A_MUL, 16'h0012, 16'h0034, 5'd0, 1'b0, 1'b1, 16'hA5A5);
        step();
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL mul_start got busy=%b rdy=%b want 1 0", busy, in_ready);
        else passed++;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            cyc++;
        end
        total++;
        if (out_valid !== 1'b1) $display("FAIL mul_timeout got %b want 1", out_valid);
        else passed++;
        total++;
        if (busy_cnt != 16) $display("FAIL mul_busy_cycles got %0d want 16", busy_cnt);
        else passed++;
        total++;
        if (aluresult !== 16'h03A8 || instrout !== 16'hA5A5)
            $display("FAIL mul_result got %h %h want 03A8 A5A5", aluresult, instrout);
        else passed++;
        total++;
        if (busy !== 1'b0 || iswb_out !== 1'b1)
            $display("FAIL mul_end got busy=%b wb=%b want 0 1", busy, iswb_out);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(A_ADD, 16'd1, 16'd2, 5'd0, 1'b0, 1'b0, 16'h3333);
        step();
        drive(A_ADD, 16'd5, 16'd6, 5'd0, 1'b0, 1'b0, 16'h4444);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || aluresult !== 16'd3 ||
                instrout !== 16'h3333 || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got v=%b %h %h rdy=%b want 1 0003 3333 0",
                         i, out_valid, aluresult, instrout, in_ready);
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready);
        else passed++;
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || aluresult !== 16'd11 || instrout !== 16'h4444)
            $display("FAIL bp_next got v=%b %h %h want 1 000b 4444",
                     out_valid, aluresult, instrout);
        else passed++;
        step();
    endtask

    task automatic test_ops();
        for (int i = 0; i < NV; i++) begin
            drive(T_OP[i], T_A[i], T_B[i], 5'd4, T_IMM[i], 1'b1, 16'(i));
            step();
            total++;
            if (out_valid !== 1'b1 || aluresult !== T_EXP[i] ||
                isld1 !== T_LD[i] || iswb_out !== 1'b1)
                $display("FAIL op%0d got v=%b %h ld=%b wb=%b want 1 %h ld=%b wb=1",
                         i, out_valid, aluresult, isld1, iswb_out, T_EXP[i], T_LD[i]);
            else passed++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush_mul();
        logic seen = 1'b0;
        drive(A_MUL, 16'd3, 16'd5, 5'd0, 1'b0, 1'b1, 16'h5555);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        flush = 1'b1;
        drive(A_ADD, 16'd9, 16'd9, 5'd0, 1'b0, 1'b1, 16'h6666);
        total++;
        if (in_ready !== 1'b0) $display("FAIL flush_rdy got %b want 0", in_ready);
        else passed++;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_abort got busy=%b v=%b want 0 0", busy, out_valid);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            step();
        end
        total++;
        if (seen !== 1'b0) $display("FAIL flush_no_result got %b want 0", seen);
        else passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL flush_idle got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_async_reset();
        logic seen = 1'b0;
        out_ready = 1'b0;
        drive(A_ADD, 16'd1, 16'd1, 5'd0, 1'b0, 1'b1, 16'h7777);
        step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || aluresult !== 16'h0 || instrout !== 16'h0 ||
            iswb_out !== 1'b0)
            $display("FAIL arst_out got v=%b %h %h wb=%b want 0 0 0 0",
                     out_valid, aluresult, instrout, iswb_out);
        else passed++;
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        drive(A_MUL, 16'd7, 16'd7, 5'd0, 1'b0, 1'b1, 16'h8888);
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL arst_mul got busy=%b want 0", busy);
        else passed++;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            step();
        end
        total++;
        if (seen !== 1'b0) $display("FAIL arst_no_result got %b want 0", seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_imm();
        test_mul();
        test_back_to_back();
        test_ops();
        test_flush_mul();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
